// File: rtl/dmix_gain_stage.sv
// Per-channel Q2.14 digital gain between resample_pipeline and dac_drv.
// One shared shift-add multiplier; round half up, saturate, sticky clip/underrun status.
module dmix_gain_stage #(
    parameter int NUM_CH      = 2,
    parameter int NUM_CH_LOG2 = 1,
    parameter int DATA_WIDTH  = 24,
    parameter int GAIN_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*GAIN_WIDTH-1:0] gain_i,
    output logic [NUM_CH-1:0]            pop_o,
    input  logic [NUM_CH-1:0]            ack_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic [NUM_CH-1:0]            pop_i,
    output logic [NUM_CH-1:0]            ack_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    input  logic                         clip_clr_i,
    output logic [NUM_CH-1:0]            clip_o,
    output logic [NUM_CH-1:0]            underrun_o
);

    localparam int ACC_WIDTH = DATA_WIDTH + GAIN_WIDTH;
    localparam int FRAC_BITS = GAIN_WIDTH - 2;
    localparam int RES_WIDTH = ACC_WIDTH - FRAC_BITS;
    localparam int CNT_WIDTH = $clog2(GAIN_WIDTH);

    localparam logic [ACC_WIDTH-1:0]  RND_BIAS = ACC_WIDTH'(1) << (FRAC_BITS - 1);
    localparam logic [DATA_WIDTH-1:0] SAT_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(GAIN_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_SAT
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   in_reg_q  [NUM_CH];
    logic [DATA_WIDTH-1:0]   out_reg_q [NUM_CH];
    logic [NUM_CH-1:0]       in_full_q, req_pending_q, out_valid_q;
    logic [NUM_CH_LOG2-1:0]  cur_ch_q, last_ch_q;
    logic [ACC_WIDTH-1:0]    acc_q, mcand_q;
    logic [GAIN_WIDTH-1:0]   mplier_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    logic                    pick_valid;
    logic [NUM_CH_LOG2-1:0]  pick_ch, cand;
    logic                    serve_valid;
    logic [NUM_CH_LOG2-1:0]  serve_ch;
    logic [RES_WIDTH-1:0]    res;
    logic [RES_WIDTH-DATA_WIDTH:0] res_top;
    logic                    sat_clip;
    logic [DATA_WIDTH-1:0]   sat_data;

    // Round-robin search starts one past the channel the multiplier served last.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
        pick_valid = 1'b0;
        pick_ch    = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = last_ch_q + NUM_CH_LOG2'(k);
            if (!pick_valid && in_full_q[cand] && !out_valid_q[cand]) begin
                pick_valid = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    always_comb begin
        serve_valid = |pop_i;
        serve_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pop_i[i]) begin
                serve_ch = NUM_CH_LOG2'(i);
            end
        end
    end

    always_comb begin
        res      = RES_WIDTH'((acc_q + RND_BIAS) >> FRAC_BITS);
        res_top  = res[RES_WIDTH-1:DATA_WIDTH-1];
        sat_clip = !((&res_top) || !(|res_top));
        if (!sat_clip) begin
            sat_data = res[DATA_WIDTH-1:0];
        end else if (res[RES_WIDTH-1]) begin
            sat_data = SAT_NEG;
        end else begin
            sat_data = SAT_POS;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_MUL;
            ST_MUL:  if (cnt_q == '0) state_d = ST_SAT;
            ST_SAT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift-add: one gain bit per MUL cycle, LSB first, multiplicand sign-extended to ACC_WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            cur_ch_q  <= '0;
            last_ch_q <= NUM_CH_LOG2'(NUM_CH - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        acc_q     <= '0;
                        mcand_q   <= {{GAIN_WIDTH{in_reg_q[pick_ch][DATA_WIDTH-1]}}, in_reg_q[pick_ch]};
                        mplier_q  <= gain_i[int'(pick_ch)*GAIN_WIDTH +: GAIN_WIDTH];
                        cnt_q     <= CNT_LAST;
                        cur_ch_q  <= pick_ch;
                        last_ch_q <= pick_ch;
                    end
                end
                ST_MUL: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the sample registers are a handful of flops, so they are reset like any other state.
            for (int c = 0; c < NUM_CH; c++) begin
                in_reg_q[c]  <= '0;
                out_reg_q[c] <= '0;
            end
            in_full_q     <= '0;
            req_pending_q <= '0;
            out_valid_q   <= '0;
            pop_o         <= '0;
            clip_o        <= '0;
            underrun_o    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pop_o[c] <= !in_full_q[c] && !req_pending_q[c];
                if (!in_full_q[c] && !req_pending_q[c]) begin
                    req_pending_q[c] <= 1'b1;
                end else if (req_pending_q[c] && ack_i[c]) begin
                    in_reg_q[c]      <= data_i;
                    in_full_q[c]     <= 1'b1;
                    req_pending_q[c] <= 1'b0;
                end
            end

            if (serve_valid && out_valid_q[serve_ch]) begin
                out_valid_q[serve_ch] <= 1'b0;
            end

            if (state_q == ST_SAT) begin
                out_reg_q[cur_ch_q]   <= sat_data;
                out_valid_q[cur_ch_q] <= 1'b1;
                in_full_q[cur_ch_q]   <= 1'b0;
            end

            // Clear wins over a flag being raised in the same cycle.
            if (clip_clr_i) begin
                clip_o     <= '0;
                underrun_o <= '0;
            end else begin
                if (state_q == ST_SAT && sat_clip) begin
                    clip_o[cur_ch_q] <= 1'b1;
                end
                if (serve_valid && !out_valid_q[serve_ch]) begin
                    underrun_o[serve_ch] <= 1'b1;
                end
            end
        end
    end

    // Downstream answer: only the lowest requested channel is served; data_o holds between acks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_o  <= '0;
            data_o <= '0;
        end else begin
            ack_o <= '0;
            if (serve_valid) begin
                ack_o[serve_ch] <= 1'b1;
                data_o          <= out_valid_q[serve_ch] ? out_reg_q[serve_ch] : '0;
            end
        end
    end

endmodule

// File: doc/dmix_gain_stage.md
# dmix_gain_stage

Per-channel digital gain stage sitting between `resample_pipeline` and `dac_drv` on the 49.152 MHz domain. It pulls samples from the resampler with the same pop/ack handshake the DAC driver uses and scales each by a programmable unsigned gain using one shared sequential shift-add multiplier. It rounds and saturates the product back to 24 bits and serves it to the DAC driver on demand. Clipping and underrun are flagged with sticky status bits.

## Interface
- `NUM_CH`, 2, number of channels.
- `NUM_CH_LOG2`, 1, log2 of NUM_CH.
- `DATA_WIDTH`, 24, signed two's-complement sample width.
- `GAIN_WIDTH`, 16, unsigned gain width, Q2.14 format (0x4000 = unity).

Ports:
- `clk`  in  1  sample-domain clock (clk491520).
- `rst`  in  1  asynchronous, active-low reset.
- `gain_i`  in  NUM_CH*GAIN_WIDTH  per-channel gain; channel c at `[c*GAIN_WIDTH +: GAIN_WIDTH]`.
- `pop_o`  out  NUM_CH  one-cycle request to upstream for a new sample of channel c.
- `ack_i`  in  NUM_CH  upstream answer; `data_i` is valid in the same cycle.
- `data_i`  in  DATA_WIDTH  upstream sample.
- `pop_i`  in  NUM_CH  downstream request, one-hot by contract.
- `ack_o`  out  NUM_CH  downstream answer, one-cycle pulse.
- `data_o`  out  DATA_WIDTH  scaled sample, valid while `ack_o` is high.
- `clip_clr_i`  in  1  clears `clip_o` and `underrun_o`.
- `clip_o`  out  NUM_CH  sticky: a saturation occurred on channel c.
- `underrun_o`  out  NUM_CH  sticky: `pop_i[c]` arrived with no result ready.

## Operation
- Per channel state: input register plus `in_full`, `req_pending`; output register plus `out_valid`.
- Upstream fetch:
  - `pop_o[c]` pulses for one cycle when `!in_full[c] && !req_pending[c]`. The same edge sets `req_pending[c]`.
  - The first `ack_i[c]` while pending latches `data_i`, sets `in_full[c]` and clears `req_pending[c]`.
  - `ack_i[c]` with no pending request is ignored.
- Multiplier FSM:
  - IDLE: round-robin pick, starting after the last served channel, of a channel c with `in_full[c] && !out_valid[c]`. On a pick, sample the sample and `gain_i[c]`, then go to MUL.
  - MUL: exactly GAIN_WIDTH cycles of shift-add. The signed 24-bit value times the unsigned 16-bit gain gives a 40-bit signed accumulator.
  - SAT: one cycle. Compute `(acc + 2^13) >>> 14` (arithmetic shift, round half toward +inf).
    - If the result is outside [-2^23, 2^23-1], clamp to 0x800000 or 0x7FFFFF and set `clip_o[c]`.
    - Write the output register, set `out_valid[c]`, clear `in_full[c]`, return to IDLE.
- Downstream serve: `pop_i[c]` at edge N produces `ack_o[c]=1` at N+1.
  - If `out_valid[c]` was set at edge N: `data_o` is the output register and `out_valid[c]` clears.
  - Otherwise: `data_o=0` and `underrun_o[c]` is set.
  - If multiple `pop_i` bits are set, only the lowest index is served; the other bits are dropped.
- `clip_clr_i` has priority over setting the flags in the same cycle.
- Gain changes take effect from the next IDLE pick; an operation in flight keeps its sampled gain.

## Timing
- Reset values: `pop_o=0`, `ack_o=0`, `data_o=0`, `clip_o=0`, `underrun_o=0`; all full/valid/pending flags 0; FSM in IDLE.
  - Reset asserted mid-MUL aborts the operation; the partial result is discarded.
- First `pop_o` edge: the first rising `clk` after `rst` deasserts, for all channels at once.
- Latency from `ack_i` to `out_valid`, for a single channel with an idle FSM:
  - 1 cycle latch, 1 cycle IDLE pick, GAIN_WIDTH MUL cycles, 1 SAT cycle: 19 cycles at defaults.
- Throughput: one channel-sample per GAIN_WIDTH+2 cycles, i.e. 18 cycles, well under 512 cycles per 96 kHz frame.
- If SAT sets `out_valid[c]` in the same cycle `pop_i[c]` is sampled, the pop sees the old value and is an underrun.
- `ack_o` is registered; `data_o` is held until the next `ack_o`.

## Test plan
- Unity gain: gain 0x4000, `data_i`=0x123456 on ch0 → `data_o`=0x123456 on the next `pop_i[0]`; `clip_o`=0.
- Saturation: gain 0x8000 (2.0), data 0x400000 → 0x7FFFFF with `clip_o[0]`=1. Data 0xC00000 → 0x800000 with no clip.
- Rounding: gain 0x2000 (0.5), data 0x000003 → 0x000002; data 0xFFFFFD → 0xFFFFFF.
- Underrun: after reset, `pop_i[1]` before any `ack_i` → `ack_o[1]` next cycle with `data_o`=0 and `underrun_o[1]`=1. Then `clip_clr_i` → 0.
- Round-robin fairness: both channels full at once → results produced ch0 then ch1, 18 cycles apart. Check no extra `pop_o` while `in_full` or `req_pending` is set.
- Reset mid-MUL: drop `rst` 8 cycles into MUL, release it → all outputs 0, `pop_o` re-issued on the first edge, and no stale `ack_o`.
